// File: rtl/layer_compositor_pkg.sv
// rtl/layer_compositor_pkg.sv - shared colour type and constants for the layer compositor
package layer_compositor_pkg;

  typedef logic [7:0] rgb_t;

  localparam rgb_t COLOR_TRANSPARENT  = 8'hFF;
  localparam rgb_t COLOR_BLACK        = 8'h00;
  localparam int   NUM_LAYERS_DEFAULT = 4;

endpackage

// File: rtl/layer_compositor_if.sv
// rtl/layer_compositor_if.sv - pixel-in / pixel-out bundle between colour stages, compositor and VGA stage
interface layer_compositor_if
  import layer_compositor_pkg::*;
#(
  parameter int NUM_LAYERS = NUM_LAYERS_DEFAULT
);

  logic                  pixelValid;
  logic                  startOfFrame;
  rgb_t                  layerRGB [NUM_LAYERS];
  rgb_t                  backgroundRGB;
  rgb_t                  RGBOut;
  logic                  RGBValid;
  logic [NUM_LAYERS-1:0] collisionFlags;
  logic                  collisionPulse;

  modport master (
    output pixelValid, startOfFrame, layerRGB, backgroundRGB,
    input  RGBOut, RGBValid, collisionFlags, collisionPulse
  );

  modport slave (
    input  pixelValid, startOfFrame, layerRGB, backgroundRGB,
    output RGBOut, RGBValid, collisionFlags, collisionPulse
  );

endinterface

// File: rtl/layer_compositor_collision_accumulator.sv
// rtl/layer_compositor_collision_accumulator.sv - per-frame record of layers overlapping the ball layer
module collision_accumulator
  import layer_compositor_pkg::*;
#(
  parameter int NUM_LAYERS = NUM_LAYERS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic [NUM_LAYERS-1:0] opaque,
  input  logic                  pixelValid,
  input  logic                  startOfFrame,
  output logic [NUM_LAYERS-1:0] collisionFlags,
  output logic                  collisionPulse
);

  logic [NUM_LAYERS-1:0] acc;
  logic [NUM_LAYERS-1:0] hit;

  always_comb begin
    hit = '0;
    for (int k = 1; k < NUM_LAYERS; k++) begin
      hit[k] = opaque[0] & opaque[k] & pixelValid;
    end
  end

  // The frame-start pixel seeds the new frame; flags only ever see the finished frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      acc            <= '0;
      collisionFlags <= '0;
      collisionPulse <= 1'b0;
    end else if (startOfFrame) begin
      collisionFlags <= acc;
      acc            <= hit;
      collisionPulse <= (acc != '0);
    end else begin
      acc            <= acc | hit;
      collisionPulse <= 1'b0;
    end
  end

endmodule

// File: rtl/layer_compositor.sv
// rtl/layer_compositor.sv - two-stage fixed-priority merge of RGB layers with ball collision tracking
module layer_compositor
  import layer_compositor_pkg::*;
#(
  parameter int NUM_LAYERS = NUM_LAYERS_DEFAULT
) (
  input  logic              clk,
  input  logic              resetN,
  layer_compositor_if.slave bus
);

  rgb_t                  s1_rgb [NUM_LAYERS];
  rgb_t                  s1_bg;
  logic                  s1_valid;
  logic                  s1_sof;
  logic [NUM_LAYERS-1:0] s1_opaque;
  rgb_t                  sel_rgb;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int k = 0; k < NUM_LAYERS; k++) begin
        s1_rgb[k]    <= COLOR_BLACK;
        s1_opaque[k] <= 1'b0;
      end
      s1_bg    <= COLOR_BLACK;
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_LAYERS; k++) begin
        s1_rgb[k]    <= bus.layerRGB[k];
        s1_opaque[k] <= (bus.layerRGB[k] != COLOR_TRANSPARENT);
      end
      s1_bg    <= bus.backgroundRGB;
      s1_valid <= bus.pixelValid;
      s1_sof   <= bus.startOfFrame;
    end
  end

  // Walk from lowest to highest priority so layer 0 wins the last assignment.
  always_comb begin
    sel_rgb = s1_bg;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (s1_opaque[k]) begin
        sel_rgb = s1_rgb[k];
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bus.RGBOut   <= COLOR_BLACK;
      bus.RGBValid <= 1'b0;
    end else begin
      bus.RGBOut   <= s1_valid ? sel_rgb : COLOR_BLACK;
      bus.RGBValid <= s1_valid;
    end
  end

  collision_accumulator #(
    .NUM_LAYERS (NUM_LAYERS)
  ) u_collision (
    .clk            (clk),
    .resetN         (resetN),
    .opaque         (s1_opaque),
    .pixelValid     (s1_valid),
    .startOfFrame   (s1_sof),
    .collisionFlags (bus.collisionFlags),
    .collisionPulse (bus.collisionPulse)
  );

endmodule

// File: tb/tb_layer_compositor.sv
// tb/tb_layer_compositor.sv - scoreboard bench for layer_compositor with directed pixel vectors
module tb_layer_compositor;
  import layer_compositor_pkg::*;

  localparam int   NL = 4;
  localparam rgb_t T  = COLOR_TRANSPARENT;

  logic clk    = 1'b0;
  logic resetN = 1'b0;
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_err  = 0;

  typedef struct {
    int          due;
    string       name;
    logic [7:0]  rgb;
    logic        vld;
    logic [3:0]  flags;
    logic        pulse;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  layer_compositor_if #(.NUM_LAYERS(NL)) bus ();

  layer_compositor #(.NUM_LAYERS(NL)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      mon_e = q.pop_front();
      n_cmp = n_cmp + 1;
      if (mon_e.due < cyc) begin
        n_err = n_err + 1;
        $display("FAIL %s: output slot missed (due cycle %0d, now %0d)", mon_e.name, mon_e.due, cyc);
      end else if (bus.RGBOut !== mon_e.rgb || bus.RGBValid !== mon_e.vld ||
                   bus.collisionFlags !== mon_e.flags || bus.collisionPulse !== mon_e.pulse) begin
        n_err = n_err + 1;
        $display("FAIL %s: got rgb=%h vld=%b flags=%b pulse=%b, want rgb=%h vld=%b flags=%b pulse=%b",
                 mon_e.name, bus.RGBOut, bus.RGBValid, bus.collisionFlags, bus.collisionPulse,
                 mon_e.rgb, mon_e.vld, mon_e.flags, mon_e.pulse);
      end
    end
  end

  task automatic set_in(input logic v, input logic s, input rgb_t l0, input rgb_t l1,
                        input rgb_t l2, input rgb_t l3, input rgb_t bg);
    bus.pixelValid    = v;
    bus.startOfFrame  = s;
    bus.layerRGB[0]   = l0;
    bus.layerRGB[1]   = l1;
    bus.layerRGB[2]   = l2;
    bus.layerRGB[3]   = l3;
    bus.backgroundRGB = bg;
  endtask

  // Apply one pixel for one cycle and queue the output expected two edges later.
  task automatic drive(input string name, input logic v, input logic s,
                       input rgb_t l0, input rgb_t l1, input rgb_t l2, input rgb_t l3, input rgb_t bg,
                       input rgb_t e_rgb, input logic e_vld, input logic [3:0] e_flags, input logic e_pulse);
    exp_t e;
    @(posedge clk);
    #1;
    set_in(v, s, l0, l1, l2, l3, bg);
    e.due   = cyc + 2;
    e.name  = name;
    e.rgb   = e_rgb;
    e.vld   = e_vld;
    e.flags = e_flags;
    e.pulse = e_pulse;
    q.push_back(e);
  endtask

  task automatic check_zero(input string name);
    n_cmp = n_cmp + 1;
    if (bus.RGBOut !== 8'h00 || bus.RGBValid !== 1'b0 ||
        bus.collisionFlags !== 4'b0000 || bus.collisionPulse !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL %s: got rgb=%h vld=%b flags=%b pulse=%b, want all zero",
               name, bus.RGBOut, bus.RGBValid, bus.collisionFlags, bus.collisionPulse);
    end
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 20;
    while (q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (q.size() > 0) begin
      n_cmp = n_cmp + 1;
      n_err = n_err + 1;
      $display("FAIL %s: %0d expected outputs never arrived", name, q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    set_in(1'b0, 1'b0, T, T, T, T, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    @(negedge clk);
    resetN = 1'b1;

    //     name          v  s  l0     l1     l2     l3     bg     rgb    vld flags    pulse
    drive("t1_layer2",   1, 0, T,     T,     8'h1C, T,     8'h00, 8'h1C, 1, 4'b0000, 0);
    drive("t3_bg",       1, 0, T,     T,     T,     T,     8'h49, 8'h49, 1, 4'b0000, 0);
    drive("t3_blank",    0, 0, T,     T,     T,     T,     8'h49, 8'h00, 0, 4'b0000, 0);
    drive("blank_ovl",   0, 0, 8'hE0, 8'h03, T,     T,     8'h49, 8'h00, 0, 4'b0000, 0);
    drive("sof_first",   1, 1, T,     T,     T,     T,     8'h00, 8'h00, 1, 4'b0000, 0);
    drive("t2_overlap",  1, 0, 8'hE0, 8'h03, T,     T,     8'h00, 8'hE0, 1, 4'b0000, 0);
    drive("t2_publish",  1, 1, T,     T,     T,     T,     8'h11, 8'h11, 1, 4'b0010, 1);
    drive("t2_pulse_end",1, 0, T,     T,     T,     T,     8'h11, 8'h11, 1, 4'b0010, 0);
    drive("t4_a_l3",     1, 0, 8'hE0, T,     T,     8'h07, 8'h00, 8'hE0, 1, 4'b0010, 0);
    drive("t4_a_l1",     1, 0, 8'h55, 8'h66, T,     T,     8'h00, 8'h55, 1, 4'b0010, 0);
    drive("t4_pub_a",    1, 1, T,     T,     T,     T,     8'h00, 8'h00, 1, 4'b1010, 1);
    drive("t4_b_noovl",  1, 0, T,     8'h22, 8'h33, T,     8'h00, 8'h22, 1, 4'b1010, 0);
    drive("t4_pub_b",    1, 1, T,     T,     T,     T,     8'h00, 8'h00, 1, 4'b0000, 0);
    drive("t5_sof_ovl",  1, 1, 8'hE0, T,     8'h1C, T,     8'h00, 8'hE0, 1, 4'b0000, 0);
    drive("t5_mid",      1, 0, T,     T,     T,     T,     8'h5A, 8'h5A, 1, 4'b0000, 0);
    drive("t5_publish",  1, 1, T,     T,     T,     T,     8'h5A, 8'h5A, 1, 4'b0100, 1);
    drive("all_collide", 1, 0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h00, 8'hA1, 1, 4'b0100, 0);
    drive("b2b_sof1",    1, 1, 8'hE0, 8'h03, T,     T,     8'h00, 8'hE0, 1, 4'b1110, 1);
    drive("b2b_sof2",    1, 1, T,     T,     T,     T,     8'h00, 8'h00, 1, 4'b0010, 1);
    drive("inv_pre",     1, 0, 8'hE0, T,     T,     8'h07, 8'h00, 8'hE0, 1, 4'b0010, 0);
    drive("inv_sof",     0, 1, 8'hE0, 8'h03, T,     T,     8'h00, 8'h00, 0, 4'b1000, 1);
    drive("inv_sof_next",0, 1, T,     T,     T,     T,     8'h00, 8'h00, 0, 4'b0000, 0);
    drive("t6_hit1",     1, 0, 8'hE0, 8'h03, T,     T,     8'h00, 8'hE0, 1, 4'b0000, 0);
    drive("t6_publish",  1, 1, T,     T,     T,     T,     8'h00, 8'h00, 1, 4'b0010, 1);
    drive("t6_hit2",     1, 0, 8'hE0, T,     8'h1C, T,     8'h00, 8'hE0, 1, 4'b0010, 0);
    drain("pre_reset");

    // Outputs now hold a live pixel and nonzero flags; reset must clear them without a clock edge.
    @(posedge clk);
    #3;
    resetN = 1'b0;
    #1;
    check_zero("async_reset");
    set_in(1'b0, 1'b0, T, T, T, T, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk);
    #1;
    check_zero("post_release");

    drive("rel_pixel",   1, 0, T,     T,     T,     T,     8'h00, 8'h00, 1, 4'b0000, 0);
    drive("rel_sof",     1, 1, T,     T,     T,     T,     8'h00, 8'h00, 1, 4'b0000, 0);
    drain("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
